// File: rtl/bfp16_operand_pair_buffer.sv
// BFP16 operand pair buffer: two independent show-ahead lane FIFOs (A from
// demux out0, B from demux out1) that issue aligned (A,B) pairs to the matmul
// multiplier over a valid/ready handshake. Operand words are opaque.
module bfp16_operand_pair_buffer #(
  parameter int DATA_TYPE = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   a_valid,
  input  logic [DATA_TYPE-1:0]   a_data,
  output logic                   a_ready,
  input  logic                   b_valid,
  input  logic [DATA_TYPE-1:0]   b_data,
  output logic                   b_ready,
  output logic                   pair_valid,
  output logic [DATA_TYPE-1:0]   pair_a,
  output logic [DATA_TYPE-1:0]   pair_b,
  input  logic                   pair_ready,
  output logic [$clog2(DEPTH):0] a_level,
  output logic [$clog2(DEPTH):0] b_level,
  output logic [CNT_W-1:0]       pair_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [DATA_TYPE-1:0] mem_a [DEPTH];
  logic [DATA_TYPE-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0]     wr_a, rd_a, wr_b, rd_b;
  logic                 a_empty, b_empty;
  logic                 push_a, push_b, pop;

  // Readiness and pair availability come only from registered levels, so
  // pair_ready never reaches a_ready/b_ready combinationally.
  always_comb begin
    a_empty    = (a_level == '0);
    b_empty    = (b_level == '0);
    a_ready    = (a_level != FULL_LVL);
    b_ready    = (b_level != FULL_LVL);
    pair_valid = !a_empty && !b_empty;
    pair_a     = a_empty ? '0 : mem_a[rd_a];
    pair_b     = b_empty ? '0 : mem_b[rd_b];
    push_a     = a_valid && a_ready && !flush;
    push_b     = b_valid && b_ready && !flush;
    pop        = pair_valid && pair_ready && !flush;
  end

  // Operand storage is data only and carries no reset.
  always_ff @(posedge clk) begin
    if (push_a) mem_a[wr_a] <= a_data;
    if (push_b) mem_b[wr_b] <= b_data;
  end

  // A-lane pointers and occupancy; flush wins over any same-cycle transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_a    <= '0;
      rd_a    <= '0;
      a_level <= '0;
    end else if (flush) begin
      wr_a    <= '0;
      rd_a    <= '0;
      a_level <= '0;
    end else begin
      if (push_a) wr_a <= wr_a + PTR_W'(1);
      if (pop)    rd_a <= rd_a + PTR_W'(1);
      case ({push_a, pop})
        2'b10:   a_level <= a_level + LVL_W'(1);
        2'b01:   a_level <= a_level - LVL_W'(1);
        default: a_level <= a_level;
      endcase
    end
  end

  // B-lane pointers and occupancy, mirroring the A lane.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_b    <= '0;
      rd_b    <= '0;
      b_level <= '0;
    end else if (flush) begin
      wr_b    <= '0;
      rd_b    <= '0;
      b_level <= '0;
    end else begin
      if (push_b) wr_b <= wr_b + PTR_W'(1);
      if (pop)    rd_b <= rd_b + PTR_W'(1);
      case ({push_b, pop})
        2'b10:   b_level <= b_level + LVL_W'(1);
        2'b01:   b_level <= b_level - LVL_W'(1);
        default: b_level <= b_level;
      endcase
    end
  end

  // Issued-pair counter, wrapping naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_count <= '0;
    end else if (flush) begin
      pair_count <= '0;
    end else if (pop) begin
      pair_count <= pair_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_bfp16_operand_pair_buffer.sv
// Testbench for bfp16_operand_pair_buffer: directed vector table plus
// hand-written sequences for backpressure/wrap and asynchronous reset.
module tb_bfp16_operand_pair_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        a_valid, b_valid, pair_ready;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, pair_valid;
  logic [15:0] pair_a, pair_b;
  logic [2:0]  a_level, b_level;
  logic [15:0] pair_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bfp16_operand_pair_buffer #(.DATA_TYPE(16), .DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .pair_valid(pair_valid), .pair_a(pair_a), .pair_b(pair_b),
    .pair_ready(pair_ready), .a_level(a_level), .b_level(b_level),
    .pair_count(pair_count)
  );

  typedef struct packed {
    logic        fl;
    logic        av;
    logic [15:0] ad;
    logic        bv;
    logic [15:0] bd;
    logic        pr;
    logic        ar;
    logic        br;
    logic        pv;
    logic [15:0] pa;
    logic [15:0] pb;
    logic [2:0]  al;
    logic [2:0]  bl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic ar, input logic br,
                           input logic pv, input logic [15:0] pa,
                           input logic [15:0] pb, input logic [2:0] al,
                           input logic [2:0] bl, input logic [15:0] cnt);
    check("a_ready",    idx, 32'(a_ready),    32'(ar));
    check("b_ready",    idx, 32'(b_ready),    32'(br));
    check("pair_valid", idx, 32'(pair_valid), 32'(pv));
    check("pair_a",     idx, 32'(pair_a),     32'(pa));
    check("pair_b",     idx, 32'(pair_b),     32'(pb));
    check("a_level",    idx, 32'(a_level),    32'(al));
    check("b_level",    idx, 32'(b_level),    32'(bl));
    check("pair_count", idx, 32'(pair_count), 32'(cnt));
  endtask

  task automatic idle_inputs();
    flush = 1'b0; a_valid = 1'b0; b_valid = 1'b0; pair_ready = 1'b0;
    a_data = 16'h0; b_data = 16'h0;
  endtask

  initial begin
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    int ia, ib, popped, exp_cnt;
    logic do_pa, do_pb, do_pop;

    // fl av ad bv bd pr | ar br pv pa pb al bl cnt
    vecs[0]  = '{1'b0,1'b1,16'h4040,1'b1,16'h4100,1'b1, 1'b1,1'b1,1'b1,16'h4040,16'h4100,3'd1,3'd1,16'd0};
    vecs[1]  = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1, 1'b1,1'b1,1'b0,16'h0000,16'h0000,3'd0,3'd0,16'd1};
    vecs[2]  = '{1'b0,1'b1,16'h4040,1'b0,16'h0000,1'b1, 1'b1,1'b1,1'b0,16'h4040,16'h0000,3'd1,3'd0,16'd1};
    vecs[3]  = '{1'b0,1'b1,16'h4100,1'b0,16'h0000,1'b1, 1'b1,1'b1,1'b0,16'h4040,16'h0000,3'd2,3'd0,16'd1};
    vecs[4]  = '{1'b0,1'b1,16'h4480,1'b0,16'h0000,1'b1, 1'b1,1'b1,1'b0,16'h4040,16'h0000,3'd3,3'd0,16'd1};
    vecs[5]  = '{1'b0,1'b1,16'h3FA0,1'b0,16'h0000,1'b1, 1'b0,1'b1,1'b0,16'h4040,16'h0000,3'd4,3'd0,16'd1};
    vecs[6]  = '{1'b0,1'b1,16'h1234,1'b1,16'h3FA0,1'b1, 1'b0,1'b1,1'b1,16'h4040,16'h3FA0,3'd4,3'd1,16'd1};
    vecs[7]  = '{1'b0,1'b0,16'h0000,1'b1,16'h4480,1'b1, 1'b1,1'b1,1'b1,16'h4100,16'h4480,3'd3,3'd1,16'd2};
    vecs[8]  = '{1'b0,1'b0,16'h0000,1'b1,16'h4100,1'b1, 1'b1,1'b1,1'b1,16'h4480,16'h4100,3'd2,3'd1,16'd3};
    vecs[9]  = '{1'b0,1'b0,16'h0000,1'b1,16'h4040,1'b1, 1'b1,1'b1,1'b1,16'h3FA0,16'h4040,3'd1,3'd1,16'd4};
    vecs[10] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1, 1'b1,1'b1,1'b0,16'h0000,16'h0000,3'd0,3'd0,16'd5};
    vecs[11] = '{1'b0,1'b1,16'h1111,1'b1,16'h2222,1'b0, 1'b1,1'b1,1'b1,16'h1111,16'h2222,3'd1,3'd1,16'd5};
    vecs[12] = '{1'b0,1'b1,16'h3333,1'b1,16'h4444,1'b0, 1'b1,1'b1,1'b1,16'h1111,16'h2222,3'd2,3'd2,16'd5};
    vecs[13] = '{1'b0,1'b1,16'h5555,1'b0,16'h0000,1'b0, 1'b1,1'b1,1'b1,16'h1111,16'h2222,3'd3,3'd2,16'd5};
    vecs[14] = '{1'b1,1'b1,16'h6666,1'b1,16'h7777,1'b1, 1'b1,1'b1,1'b0,16'h0000,16'h0000,3'd0,3'd0,16'd0};
    vecs[15] = '{1'b0,1'b0,16'h0000,1'b0,16'h0000,1'b1, 1'b1,1'b1,1'b0,16'h0000,16'h0000,3'd0,3'd0,16'd0};

    // Reset then idle
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all(100, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 16'd0);

    // Vector table: basic pair, skewed arrival, flush priority
    for (int i = 0; i < 16; i++) begin
      flush = vecs[i].fl; a_valid = vecs[i].av; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_data = vecs[i].bd; pair_ready = vecs[i].pr;
      @(posedge clk); #1;
      check_all(i, vecs[i].ar, vecs[i].br, vecs[i].pv, vecs[i].pa,
                vecs[i].pb, vecs[i].al, vecs[i].bl, vecs[i].cnt);
    end
    idle_inputs();

    // Backpressure and wrap: 7 cycles with pair_ready low (fill to full and
    // hold offered words), then alternate pair_ready until 10 pairs issued.
    ia = 0; ib = 0; popped = 0; exp_cnt = 0;
    for (int c = 0; c < 80 && popped < 10; c++) begin
      a_valid = (ia < 10); a_data = 16'hA000 + 16'(ia);
      b_valid = (ib < 10); b_data = 16'hB000 + 16'(ib);
      pair_ready = (c < 7) ? 1'b0 : c[0];
      do_pa  = a_valid && (qa.size() < 4);
      do_pb  = b_valid && (qb.size() < 4);
      do_pop = pair_ready && (qa.size() > 0) && (qb.size() > 0);
      @(posedge clk); #1;
      if (do_pop) begin
        void'(qa.pop_front()); void'(qb.pop_front());
        popped++; exp_cnt++;
      end
      if (do_pa) begin qa.push_back(a_data); ia++; end
      if (do_pb) begin qb.push_back(b_data); ib++; end
      check_all(200 + c, (qa.size() != 4), (qb.size() != 4),
                (qa.size() > 0) && (qb.size() > 0),
                (qa.size() > 0) ? qa[0] : 16'h0,
                (qb.size() > 0) ? qb[0] : 16'h0,
                3'(qa.size()), 3'(qb.size()), 16'(exp_cnt));
    end
    check("stream_pairs_issued", 300, 32'(popped), 32'd10);
    idle_inputs();
    @(posedge clk); #1;
    check_all(301, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 16'd10);

    // Async reset mid-stream
    a_valid = 1'b1; a_data = 16'h4040; b_valid = 1'b1; b_data = 16'h4100;
    @(posedge clk); #1;
    idle_inputs();
    check_all(400, 1'b1, 1'b1, 1'b1, 16'h4040, 16'h4100, 3'd1, 3'd1, 16'd10);
    #2;
    rst_n = 1'b0;
    #1;
    check_all(401, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pair_ready = 1'b1;
    @(posedge clk); #1;
    check_all(402, 1'b1, 1'b1, 1'b0, 16'h0, 16'h0, 3'd0, 3'd0, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
